// File: rtl/beta_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : beta_fetch_unit
// Brief    : Instruction fetch stage. Owns the PC, issues one word request
//            at a time on the imem req/gnt/rvalid bus, registers the returned
//            word and hands it to the decoder with a valid/ready handshake.
//            Redirects flush any in-flight fetch.
// Options  : BETA_FETCH_PERF_EN builds the fetch/stall performance counters;
//            without it perf_fetch_o/perf_stall_o read as zero.
// Revision : 1.0 - initial release
// ============================================================================
module beta_fetch_unit #(
  parameter int unsigned         XLEN      = 32,
  parameter logic [XLEN-1:0]     BOOT_ADDR = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            imem_err_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            fetch_err_o,
  output logic            fetch_misaligned_o,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_stall_o
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic            err_q, err_d;
  logic            mis_q, mis_d;

  // PC that the next fetch would use: a redirect this cycle overrides pc_q
  logic [XLEN-1:0] next_tgt;
  logic            tgt_mis;
  logic            go_mis;

  assign next_tgt = redirect_i ? redirect_pc_i : pc_q;
  assign tgt_mis  = |next_tgt[1:0];

  // Next-state logic: misaligned targets bypass the bus and present a NOP
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    err_d    = err_q;
    mis_d    = mis_q;
    go_mis   = 1'b0;

    if (redirect_i) begin
      pc_d  = redirect_pc_i;
      mis_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (imem_gnt_i) begin
          // A redirect racing the grant leaves a response we must discard
          state_d = ST_WAIT;
          kill_d  = redirect_i;
        end else if (redirect_i && tgt_mis) begin
          go_mis = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (kill_q || redirect_i) begin
            if (tgt_mis) go_mis = 1'b1;
            else         state_d = ST_REQ;
          end else begin
            state_d  = ST_VALID;
            instr_d  = imem_rdata_i;
            pc_out_d = pc_q;
            err_d    = imem_err_i;
            mis_d    = 1'b0;
          end
        end else if (redirect_i) begin
          // Stay until the outstanding response drains; one request at a time
          kill_d = 1'b1;
        end
      end
      ST_VALID: begin
        if (redirect_i) begin
          if (tgt_mis) go_mis = 1'b1;
          else         state_d = ST_REQ;
        end else if (instr_ready_i) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    if (go_mis) begin
      state_d  = ST_VALID;
      instr_d  = NOP;
      pc_out_d = next_tgt;
      err_d    = 1'b0;
      mis_d    = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_REQ;
      pc_q     <= BOOT_ADDR;
      kill_q   <= 1'b0;
      instr_q  <= NOP;
      pc_out_q <= BOOT_ADDR;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
    end
  end

  assign imem_req_o         = rstn_i && (state_q == ST_REQ);
  assign imem_addr_o        = {pc_q[XLEN-1:2], 2'b00};
  assign instr_valid_o      = (state_q == ST_VALID);
  assign instr_o            = instr_q;
  assign pc_o               = pc_out_q;
  assign fetch_err_o        = err_q;
  assign fetch_misaligned_o = mis_q;

`ifdef BETA_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count accepted instructions and empty-output cycles, wrapping freely
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (instr_valid_o && instr_ready_i && !redirect_i) perf_fetch_d = perf_fetch_q + 32'd1;
    if (!instr_valid_o)                                perf_stall_d = perf_stall_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_fetch_o = 32'd0;
  assign perf_stall_o = 32'd0;
`endif

`ifndef SYNTHESIS
  a_rvalid_only_in_wait: assert property (@(posedge clk_i) disable iff (!rstn_i)
    imem_rvalid_i |-> (state_q == ST_WAIT));
`endif

endmodule
`default_nettype wire

// File: tb/tb_beta_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_fetch_unit
// Brief    : Self-checking bench for beta_fetch_unit: directed cycle table,
//            hand-written corner sequences, and a randomized run against a
//            transaction-level reference model with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_fetch_unit;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          NV   = 24;
  localparam int          NRND = 4000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, gnt, rvalid, ierr, valid, ready, redir, ferr, fmis;
  logic [31:0] addr, rdata, instr, pc, rpc, perf_fetch, perf_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  beta_fetch_unit #(.XLEN(32), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .imem_err_i(ierr),
    .instr_o(instr), .pc_o(pc), .instr_valid_o(valid), .instr_ready_i(ready),
    .redirect_i(redir), .redirect_pc_i(rpc),
    .fetch_err_o(ferr), .fetch_misaligned_o(fmis),
    .perf_fetch_o(perf_fetch), .perf_stall_o(perf_stall)
  );

  typedef struct {
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        err, ready, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    logic        e_err, e_mis;
  } vec_t;

  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd, input logic e,
                              input logic rdy, input logic rdr, input logic [31:0] tp,
                              input logic xq, input logic [31:0] xa, input logic xv,
                              input logic [31:0] xp, input logic [31:0] xi, input logic xe,
                              input logic xm);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.err = e; v.ready = rdy; v.redir = rdr; v.rpc = tp;
    v.e_req = xq; v.e_addr = xa; v.e_valid = xv; v.e_pc = xp; v.e_instr = xi;
    v.e_err = xe; v.e_mis = xm;
    return v;
  endfunction

  // Behavioural instruction memory contents and error map
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'hB;
  endfunction

  task automatic clear_inputs();
    gnt = 0; rvalid = 0; rdata = 0; ierr = 0; ready = 0; redir = 0; rpc = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, req},   0);
    check({tag, "_valid"}, {31'd0, valid}, 0);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_pc"},    pc, BOOT);
    check({tag, "_err"},   {31'd0, ferr},  0);
    check({tag, "_mis"},   {31'd0, fmis},  0);
    check({tag, "_perf_fetch"}, perf_fetch, 0);
    check({tag, "_perf_stall"}, perf_stall, 0);
  endtask

  initial begin : main
    logic [31:0] exp_pc, pend_addr, tgt;
    logic        outstanding, had_pend;
    int unsigned delay;
    int          hs, m_fetch, m_stall;
    logic [31:0] e_fetch, e_stall;

    // --- directed cycle table: basic fetch, stall, redirect in WAIT, error, misaligned
    tbl[0]  = mk(1,0,0,0,0,0,0,              1,32'h000,0,0,0,0,0);
    tbl[1]  = mk(0,1,32'h0000_0113,0,1,0,0,  0,0,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,1,0,0,              0,0,1,32'h000,32'h0000_0113,0,0);
    tbl[3]  = mk(1,0,0,0,0,0,0,              1,32'h004,0,0,0,0,0);
    tbl[4]  = mk(0,1,32'h0020_0193,0,1,0,0,  0,0,0,0,0,0,0);
    tbl[5]  = mk(0,0,0,0,1,0,0,              0,0,1,32'h004,32'h0020_0193,0,0);
    tbl[6]  = mk(1,0,0,0,0,0,0,              1,32'h008,0,0,0,0,0);
    tbl[7]  = mk(0,1,32'h0050_0093,0,0,0,0,  0,0,0,0,0,0,0);
    tbl[8]  = mk(0,0,0,0,0,0,0,              0,0,1,32'h008,32'h0050_0093,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0,              0,0,1,32'h008,32'h0050_0093,0,0);
    tbl[10] = mk(0,0,0,0,0,0,0,              0,0,1,32'h008,32'h0050_0093,0,0);
    tbl[11] = mk(0,0,0,0,1,0,0,              0,0,1,32'h008,32'h0050_0093,0,0);
    tbl[12] = mk(1,0,0,0,0,0,0,              1,32'h00C,0,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,1,32'h100,        0,0,0,0,0,0,0);
    tbl[14] = mk(0,1,32'hDEAD_BEEF,0,1,0,0,  0,0,0,0,0,0,0);
    tbl[15] = mk(1,0,0,0,0,0,0,              1,32'h100,0,0,0,0,0);
    tbl[16] = mk(0,1,32'h0000_0073,1,0,0,0,  0,0,0,0,0,0,0);
    tbl[17] = mk(0,0,0,0,1,0,0,              0,0,1,32'h100,32'h0000_0073,1,0);
    tbl[18] = mk(1,0,0,0,0,0,0,              1,32'h104,0,0,0,0,0);
    tbl[19] = mk(0,1,32'h0040_0213,0,0,0,0,  0,0,0,0,0,0,0);
    tbl[20] = mk(0,0,0,0,1,1,32'h102,        0,0,1,32'h104,32'h0040_0213,0,0);
    tbl[21] = mk(0,0,0,0,0,1,32'h200,        0,0,1,32'h102,NOP,0,1);
    tbl[22] = mk(0,0,0,0,0,0,0,              1,32'h200,0,0,0,0,0);
    tbl[23] = mk(0,0,0,0,0,0,0,              1,32'h200,0,0,0,0,0);

    rstn = 1'b1;
    clear_inputs();
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      #1;
      check($sformatf("t%0d_req", i),   {31'd0, req},   {31'd0, tbl[i].e_req});
      check($sformatf("t%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_req) check($sformatf("t%0d_addr", i), addr, tbl[i].e_addr);
      if (tbl[i].e_valid) begin
        check($sformatf("t%0d_pc", i),    pc,    tbl[i].e_pc);
        check($sformatf("t%0d_instr", i), instr, tbl[i].e_instr);
        check($sformatf("t%0d_err", i),   {31'd0, ferr}, {31'd0, tbl[i].e_err});
        check($sformatf("t%0d_mis", i),   {31'd0, fmis}, {31'd0, tbl[i].e_mis});
      end
      gnt = tbl[i].gnt; rvalid = tbl[i].rvalid; rdata = tbl[i].rdata; ierr = tbl[i].err;
      ready = tbl[i].ready; redir = tbl[i].redir; rpc = tbl[i].rpc;
      @(negedge clk);
    end
    #1;
    clear_inputs();
`ifdef BETA_FETCH_PERF_EN
    check("table_perf_fetch", perf_fetch, 32'd4);
    check("table_perf_stall", perf_stall, 32'd15);
`else
    check("table_perf_fetch", perf_fetch, 32'd0);
    check("table_perf_stall", perf_stall, 32'd0);
`endif

    // --- PC wrap at the top of the address space
    redir = 1; rpc = 32'hFFFF_FFFC;
    step();
    check("wrap_req", {31'd0, req}, 1);
    check("wrap_addr_top", addr, 32'hFFFF_FFFC);
    redir = 0; gnt = 1;
    step();
    gnt = 0; rvalid = 1; rdata = 32'h1111_1111;
    step();
    check("wrap_valid", {31'd0, valid}, 1);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    rvalid = 0; ready = 1;
    step();
    check("wrap_addr_zero", addr, 32'h0000_0000);
    // redirect before grant moves the request address
    ready = 0; redir = 1; rpc = 32'h40;
    step();
    check("pregrant_req", {31'd0, req}, 1);
    check("pregrant_addr", addr, 32'h40);
    redir = 0; gnt = 1;
    step();
    gnt = 0;
    check("wait_req_low", {31'd0, req}, 0);

    // --- asynchronous reset in the middle of WAIT
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("post_reset_req", {31'd0, req}, 1);
    check("post_reset_addr", addr, BOOT);

    // --- randomized run against the reference model
    exp_pc = BOOT; outstanding = 0; pend_addr = 0; delay = 0;
    hs = 0; m_fetch = 0; m_stall = 0;
    for (int c = 0; c < NRND; c++) begin
      clear_inputs();
      rdata = $urandom;
      had_pend = outstanding;
      if (outstanding) begin
        if (delay == 0) begin
          rvalid = 1; rdata = mem_word(pend_addr); ierr = mem_err(pend_addr);
          outstanding = 0;
        end else begin
          delay--;
        end
      end
      if (req) begin
        check("rnd_single_outstanding", {31'd0, had_pend}, 0);
        if ($urandom_range(0, 2) != 0) begin
          gnt = 1;
          check("rnd_addr_aligned", {30'd0, addr[1:0]}, 0);
          pend_addr = addr; outstanding = 1; delay = $urandom_range(0, 3);
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redir = 1;
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
        else                           tgt = 32'($urandom_range(0, 255)) << 2;
        rpc = tgt;
      end
      if (!valid) m_stall++;
      if (valid && ready && !redir) begin
        check("rnd_pc",    pc,    exp_pc);
        check("rnd_instr", instr, mem_word(exp_pc));
        check("rnd_err",   {31'd0, ferr}, {31'd0, mem_err(exp_pc)});
        check("rnd_mis",   {31'd0, fmis}, 0);
        exp_pc = exp_pc + 32'd4;
        hs++; m_fetch++;
      end
      if (redir) exp_pc = rpc;
      step();
    end
    clear_inputs();
    check("rnd_progress", {31'd0, hs > 300}, 1);
`ifdef BETA_FETCH_PERF_EN
    e_fetch = 32'(m_fetch); e_stall = 32'(m_stall);
`else
    e_fetch = 32'd0; e_stall = 32'd0;
`endif
    check("rnd_perf_fetch", perf_fetch, e_fetch);
    check("rnd_perf_stall", perf_stall, e_stall);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
